// File: rtl/claw_step_driver_if.sv
// Bundle of the run-control and counter-strobe signals of claw_step_driver.
// Handshake: Start/Abort are level requests sampled on every rising clk edge;
// there is no ready/ack, and the result is observed on Busy/Done/Err.
// The slave modport is the driver and the master modport is its controller.
interface claw_step_driver_if;
  logic       Start;
  logic       Abort;
  logic       Cnt_10;
  logic       Add;
  logic       CntReset;
  logic       Busy;
  logic       Done;
  logic       Err;
  logic [3:0] Steps;

  modport master (
    output Start, Abort, Cnt_10,
    input  Add, CntReset, Busy, Done, Err, Steps
  );

  modport slave (
    input  Start, Abort, Cnt_10,
    output Add, CntReset, Busy, Done, Err, Steps
  );
endinterface

// File: rtl/claw_step_driver.sv
// claw_step_driver: steps a downstream decade counter by strobing Add until the
// counter reports its terminal count (Cnt_10). The counter is cleared first via
// CntReset. Abort cancels a run and clears the counter again.
// Optional macro STEP_SHADOW_CHECK_EN: compares the local Steps shadow count
// with Cnt_10 in CHECK and flags Err (then aborts) on disagreement.
// All outputs are registered and are decoded from the next state, so they line
// up with the state register. dbg_state exposes the FSM state.
module claw_step_driver #(
  parameter int ADD_HIGH = 4,
  parameter int ADD_LOW  = 4,
  parameter int RST_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 Reset,
  claw_step_driver_if.slave    bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLR      = 3'd1,
    S_PULSE_HI = 3'd2,
    S_PULSE_LO = 3'd3,
    S_CHECK    = 3'd4,
    S_DONE     = 3'd5,
    S_ABRT     = 3'd6
  } state_t;

  // Counters count down to zero, so each load is the duration minus one.
  localparam logic [7:0] HI_LOAD  = 8'(ADD_HIGH - 1);
  localparam logic [7:0] LO_LOAD  = 8'(ADD_LOW - 1);
  localparam logic [7:0] RST_LOAD = 8'(RST_CYC - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_load;
  logic       cnt_zero;
  logic       add_q;
  logic       cnt_reset_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] steps_q;
  logic       run_start;
  logic       step_edge;

  assign cnt_zero  = (cnt == 8'd0);
  assign run_start = (state == S_IDLE) && (state_next == S_CLR);
  assign step_edge = (state == S_PULSE_HI) && (state_next == S_PULSE_LO);

`ifdef STEP_SHADOW_CHECK_EN
  logic shadow_err;
  logic err_q;
`endif

  // Next-state decode; Abort outranks every other exit of the active states.
  always_comb begin
    state_next = state;
`ifdef STEP_SHADOW_CHECK_EN
    shadow_err = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (bus.Start && !bus.Abort) state_next = S_CLR;
      end
      S_CLR: begin
        if (bus.Abort)     state_next = S_ABRT;
        else if (cnt_zero) state_next = S_PULSE_HI;
      end
      S_PULSE_HI: begin
        if (bus.Abort)     state_next = S_ABRT;
        else if (cnt_zero) state_next = S_PULSE_LO;
      end
      S_PULSE_LO: begin
        if (bus.Abort)     state_next = S_ABRT;
        else if (cnt_zero) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (bus.Abort) begin
          state_next = S_ABRT;
        end else begin
          if (bus.Cnt_10) state_next = S_DONE;
          else            state_next = S_PULSE_HI;
`ifdef STEP_SHADOW_CHECK_EN
          // Counter and shadow count disagree about reaching nine steps.
          if (bus.Cnt_10 != (steps_q == 4'd9)) begin
            shadow_err = 1'b1;
            state_next = S_ABRT;
          end
`endif
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_ABRT: begin
        if (cnt_zero) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Duration to load into the cycle counter when entering a timed state.
  always_comb begin
    cnt_load = 8'd0;
    case (state_next)
      S_CLR, S_ABRT: cnt_load = RST_LOAD;
      S_PULSE_HI:    cnt_load = HI_LOAD;
      S_PULSE_LO:    cnt_load = LO_LOAD;
      default:       cnt_load = 8'd0;
    endcase
  end

  // State, cycle counter, and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      add_q       <= 1'b0;
      cnt_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      steps_q     <= 4'd0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= cnt_load;
      else if (!cnt_zero)      cnt <= cnt - 8'd1;

      add_q       <= (state_next == S_PULSE_HI);
      cnt_reset_q <= (state_next == S_CLR) || (state_next == S_ABRT);
      busy_q      <= (state_next == S_CLR) || (state_next == S_PULSE_HI) ||
                     (state_next == S_PULSE_LO) || (state_next == S_CHECK) ||
                     (state_next == S_ABRT);
      done_q      <= (state_next == S_DONE);

      if (run_start)                   steps_q <= 4'd0;
      else if (step_edge && steps_q != 4'd15) steps_q <= steps_q + 4'd1;
    end
  end

`ifdef STEP_SHADOW_CHECK_EN
  // Sticky mismatch flag, cleared only when a new run starts.
  always_ff @(posedge clk) begin
    if (Reset)           err_q <= 1'b0;
    else if (run_start)  err_q <= 1'b0;
    else if (shadow_err) err_q <= 1'b1;
  end
  assign bus.Err = err_q;
`else
  assign bus.Err = 1'b0;
`endif

  assign bus.Add      = add_q;
  assign bus.CntReset = cnt_reset_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Steps    = steps_q;
  assign dbg_state    = state;

endmodule
